// File: rtl/hazard_stall_controller.sv
// Pipeline hazard sequencer: load-use bubbles, branch flushes and data-memory freeze
// with a timeout fault and saturating stall/flush counters.
module hazard_stall_controller #(
   parameter int REG_AW      = 5,
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_uses_rs2,
   input  logic              idex_memread,
   input  logic [REG_AW-1:0] idex_rd,
   input  logic              exmem_branch_taken,
   input  logic              exmem_mem_req,
   input  logic              dmem_ready,
   output logic              hz_ctrl,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              exmem_flush,
   output logic              pipe_hold,
   output logic              mem_fault,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_count
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } state_t;

   // Wide enough to reach MEM_TIMEOUT plus one without wrapping.
   localparam int WCW = $clog2(MEM_TIMEOUT + 2);
   localparam logic [WCW-1:0] TMO = WCW'(MEM_TIMEOUT);

   state_t         state;
   logic [WCW-1:0] wait_cnt;
   logic           load_use;
   logic           freeze;
   logic           flush;
   logic           bubble;

   always_comb begin
      load_use = idex_memread && (idex_rd != '0) &&
                 ((idex_rd == id_rs1) || (id_uses_rs2 && (idex_rd == id_rs2)));
      freeze   = ((state == RUN) && exmem_mem_req && !dmem_ready) ||
                 ((state == MEM_WAIT) && !dmem_ready) ||
                 (state == FAULT);
      flush    = exmem_branch_taken && !freeze;
      bubble   = load_use && !freeze && !flush;

      pipe_hold   = freeze;
      pc_write    = !freeze && !bubble;
      ifid_write  = !freeze && !bubble;
      hz_ctrl     = bubble;
      ifid_flush  = flush;
      idex_flush  = flush;
      exmem_flush = flush;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RUN;
         wait_cnt     <= '0;
         mem_fault    <= 1'b0;
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         case (state)
            RUN: begin
               if (exmem_mem_req && !dmem_ready) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= WCW'(1);
               end
            end
            MEM_WAIT: begin
               if (dmem_ready) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if ((MEM_TIMEOUT != 0) && (wait_cnt == TMO)) begin
                  state     <= FAULT;
                  mem_fault <= 1'b1;
               end else if (wait_cnt != '1) begin
                  wait_cnt <= wait_cnt + WCW'(1);
               end
            end
            FAULT:   state <= FAULT;
            default: state <= RUN;
         endcase

         if ((freeze || bubble) && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (flush && (flush_count != '1))
            flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule
